sqrt_req_arbiter: RTL and testbench
===================================

Name: sqrt_req_arbiter

Overview:
Shares one sqrtFixedPoint datapath among NUM_REQ independent requesters. Each cycle it grants at most one request, round-robin, and drives the operand to the shared unit. A tag pipeline matched to the unit's fixed latency returns each result to the requester that issued it. Sits between client logic (board tops, filter stages) and the single sqrt instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand/result width, matches sqrtFixedPoint
LATENCY, 1, cycles from operand presented on o_sqrt_data to its result on i_sqrt_result (>=1)
ID_W, 2, requester index width, max(1, clog2(NUM_REQ))

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester request valid
i_req_data  in  NUM_REQ*DATA_W  operands, requester k at [k*DATA_W +: DATA_W]
o_req_ready  out  NUM_REQ  one-hot grant; transfer on valid&ready
o_sqrt_data  out  DATA_W  operand to shared sqrt unit
i_sqrt_result  in  DATA_W  result from shared sqrt unit
o_rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle
o_rsp_data  out  DATA_W  result for strobed requester
o_rsp_id  out  ID_W  index of strobed requester
o_busy  out  1  any request in flight

Behaviour:
- One clock, i_clk. Asynchronous active-low reset i_reset_n. Reset values: pending=0, tag pipeline all invalid, rr pointer=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_busy=0.
- Eligible[k] = i_req_valid[k] & ~pending[k]. At most one outstanding op per requester.
- Grant (combinational): search from rr pointer upward, mod NUM_REQ. The first eligible k gets o_req_ready[k]=1 and all others 0. No eligible requester gives o_req_ready=0.
- o_req_ready depends on i_req_valid. Requesters must not make valid depend on ready.
- o_sqrt_data = granted operand, or 0 when there is no grant. Combinational.
- At an edge with a grant to k: pending[k]<=1, rr pointer<=(k+1) mod NUM_REQ, tag stage0<={1,k}. With no grant: stage0<={0,x} and the pointer holds.
- The tag shifts through LATENCY register stages. The tag at stage LATENCY-1 is aligned with i_sqrt_result.
- Response is registered. If the aligned tag is valid with id j: o_rsp_valid<=onehot(j), o_rsp_id<=j, o_rsp_data<=i_sqrt_result, pending[j]<=0. Otherwise o_rsp_valid<=0 and data/id hold.
- Handshake edge at cycle t gives response visible in cycle t+LATENCY+1. Requester j may be re-granted in its response-visible cycle.
- Throughput is one op per cycle across requesters. Back-to-back grants to different requesters produce back-to-back responses in grant order.
- Simultaneous response-clear and new grant for the same requester cannot collide, because a grant requires pending=0.
- o_busy = |pending (registered-derived).
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. Results still emerging from the sqrt unit afterwards are ignored.
- No response backpressure. Clients must accept o_rsp_valid.

Decomposition:
- Package sqrt_arb_pkg: default NUM_REQ/DATA_W/LATENCY constants, clog2-based ID width function, tag struct/typedef {valid, id}.
- Sub-module sqrt_rr_pick: combinational round-robin pick. Inputs are the eligible vector and the pointer; outputs are the one-hot grant, the index and any_grant.
- Tag pipeline and response register stay in the top.

Test Plan:
Bench stand-in sqrt model returns ~x delayed LATENCY cycles.
- Single request: LATENCY=1, req1 valid with 8'h10 → ready1 same cycle, o_sqrt_data=8'h10. Two cycles after the handshake: o_rsp_valid=4'b0010, id=1, data=8'hEF for one cycle. o_busy=1 in between.
- Simultaneous requests: req0=8'h01, req2=8'h02 at reset pointer 0 → req0 granted first, req2 next cycle. Responses appear in consecutive cycles: id0/8'hFE, then id2/8'hFD.
- Fairness: all 4 hold valid continuously → grant order 0,1,2,3, repeating with one grant per cycle once responses clear pending. No requester is starved over 100 cycles.
- Pending block: req3 holds valid after its handshake → ready3 stays 0 until its response cycle, then ready3=1 in that cycle.
- Reset mid-flight: assert i_reset_n=0 one cycle after granting req1 → all outputs 0 immediately. No o_rsp_valid follows. The pointer restarts at 0.
- Latency param: LATENCY=3 with back-to-back grants to 0,1,2 → responses visible exactly 4 cycles after each handshake, with ids 0,1,2 and correct ~x data.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// ----------------------------------------------------------------------------
// sqrt_arb_pkg
// Shared definitions for the sqrt request arbiter: default sizing constants,
// the requester-index width helper and the tag carried alongside each
// operand while the shared sqrt unit is working on it.
// ----------------------------------------------------------------------------
package sqrt_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LATENCY = 1;

  // Widest requester index the arbiter supports (up to 8 requesters).
  localparam int MAX_ID_W = 3;

  // Requester index width, never narrower than one bit.
  function automatic int idWidth(input int numReq);
    return (numReq <= 2) ? 1 : $clog2(numReq);
  endfunction

  // The id field is sized for the largest configuration; smaller
  // configurations zero-extend into it.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sqrt_rr_pick.sv
// ----------------------------------------------------------------------------
// sqrt_rr_pick
// Combinational round-robin picker. Starting at the pointer and wrapping
// modulo NUM_REQ, the first eligible requester wins.
//
// Ports:
//   i_eligible  requesters allowed to win this cycle
//   i_ptr       highest-priority index this cycle
//   o_grant     one-hot winner (all zero when nobody is eligible)
//   o_idx       index of the winner (0 when nobody is eligible)
//   o_any       a winner exists
// ----------------------------------------------------------------------------
module sqrt_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Walk the candidates in priority order; the found flag keeps the first
  // hit so no break is needed. One extra sum bit makes the wrap compare safe.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(off);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!o_any && i_eligible[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// ----------------------------------------------------------------------------
// sqrt_req_arbiter
// Shares one fixed-latency sqrt datapath between NUM_REQ requesters. One
// request is granted per cycle, round-robin; a tag pipeline the length of
// the unit's latency steers each result back to its requester.
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_req_valid       per-requester request valid
//   i_req_data        operands, requester k at [k*DATA_W +: DATA_W]
//   o_req_ready       one-hot grant, transfer on valid & ready
//   o_sqrt_data       operand to the shared sqrt unit (0 when idle)
//   i_sqrt_result     result from the shared sqrt unit
//   o_rsp_valid       one-hot one-cycle response strobe
//   o_rsp_data        result for the strobed requester
//   o_rsp_id          index of the strobed requester
//   o_busy            at least one operation in flight
// ----------------------------------------------------------------------------
module sqrt_req_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ID_W    = idWidth(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [DATA_W-1:0]       o_sqrt_data,
  input  logic [DATA_W-1:0]       i_sqrt_result,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic                    o_busy
);

  logic [NUM_REQ-1:0] r_pending;
  logic [ID_W-1:0]    r_ptr;
  tag_t               r_tag [LATENCY];
  logic [NUM_REQ-1:0] r_rspValid;
  logic [DATA_W-1:0]  r_rspData;
  logic [ID_W-1:0]    r_rspId;

  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grantIdx;
  logic               w_anyGrant;
  logic [ID_W-1:0]    w_ptrNext;
  tag_t               w_align;
  logic [NUM_REQ-1:0] w_clear;

  // A requester with an operation in flight sits out until its result returns.
  assign w_eligible = i_req_valid & ~r_pending;

  sqrt_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_grantIdx),
    .o_any      (w_anyGrant)
  );

  assign o_req_ready = w_grant;

  // Mux the winning operand onto the shared unit; zero when idle.
  always_comb begin
    o_sqrt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        o_sqrt_data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Priority moves to the requester just after the winner.
  always_comb begin
    w_ptrNext = r_ptr;
    if (w_anyGrant) begin
      w_ptrNext = (w_grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + ID_W'(1);
    end
  end

  // The last tag stage lines up with the result currently on i_sqrt_result.
  assign w_align = r_tag[LATENCY-1];

  always_comb begin
    w_clear = '0;
    if (w_align.valid) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_align.id == MAX_ID_W'(k)) begin
          w_clear[k] = 1'b1;
        end
      end
    end
  end

  // Reset drops every in-flight tag, so results still inside the sqrt unit
  // afterwards find no valid tag and are ignored.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_anyGrant, id: MAX_ID_W'(w_grantIdx)};
      for (int i = 1; i < LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // A grant needs pending clear, so set and clear never hit the same bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= '0;
      r_ptr     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_grant;
      r_ptr     <= w_ptrNext;
    end
  end

  // Registered response; data and id hold between strobes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_rspId    <= '0;
    end else begin
      r_rspValid <= w_clear;
      if (w_align.valid) begin
        r_rspData <= i_sqrt_result;
        r_rspId   <= w_align.id[ID_W-1:0];
      end
    end
  end

  assign o_rsp_valid = r_rspValid;
  assign o_rsp_data  = r_rspData;
  assign o_rsp_id    = r_rspId;
  assign o_busy      = |r_pending;

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sqrt_req_arbiter
// Directed bench for sqrt_req_arbiter. dut1 runs with LATENCY=1 and dut3
// with LATENCY=3; each is fed by a stand-in sqrt unit that returns the
// bitwise inverse of its operand after the matching number of cycles.
// ----------------------------------------------------------------------------
module tb_sqrt_req_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  reqValid1, ready1, rspValid1;
  logic [31:0] reqData1;
  logic [7:0]  sqrtData1, sqrtResult1, rspData1;
  logic [1:0]  rspId1;
  logic        busy1;

  logic [3:0]  reqValid3, ready3, rspValid3;
  logic [31:0] reqData3;
  logic [7:0]  sqrtData3, sqrtResult3, rspData3;
  logic [1:0]  rspId3;
  logic        busy3;

  logic [7:0]  model3 [3];

  int checks;
  int failures;

  sqrt_req_arbiter #(.NUM_REQ(4), .DATA_W(8), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(reqValid1), .i_req_data(reqData1),
    .o_req_ready(ready1), .o_sqrt_data(sqrtData1), .i_sqrt_result(sqrtResult1),
    .o_rsp_valid(rspValid1), .o_rsp_data(rspData1), .o_rsp_id(rspId1), .o_busy(busy1)
  );

  sqrt_req_arbiter #(.NUM_REQ(4), .DATA_W(8), .LATENCY(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(reqValid3), .i_req_data(reqData3),
    .o_req_ready(ready3), .o_sqrt_data(sqrtData3), .i_sqrt_result(sqrtResult3),
    .o_rsp_valid(rspValid3), .o_rsp_data(rspData3), .o_rsp_id(rspId3), .o_busy(busy3)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in sqrt units: inverse of the operand, delayed 1 and 3 cycles.
  // They deliberately ignore reset, like a real datapath might.
  always @(posedge clk) begin
    sqrtResult1 <= ~sqrtData1;
    model3[0]   <= ~sqrtData3;
    model3[1]   <= model3[0];
    model3[2]   <= model3[1];
  end
  assign sqrtResult3 = model3[2];

  // Hard stop in case something stalls the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Move to just after the next rising edge, where inputs are driven.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v1, input logic [31:0] d1,
                               input logic [3:0] v3, input logic [31:0] d3);
    reqValid1 = v1;
    reqData1  = d1;
    reqValid3 = v3;
    reqData3  = d3;
  endtask

  task automatic do_reset();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ready1 !== 4'b0)     begin failures++; $display("[TB] FAIL reset_ready1 got=%b want=0000", ready1); end
    checks++; if (rspValid1 !== 4'b0)  begin failures++; $display("[TB] FAIL reset_rspValid1 got=%b want=0000", rspValid1); end
    checks++; if (rspData1 !== 8'h00)  begin failures++; $display("[TB] FAIL reset_rspData1 got=%h want=00", rspData1); end
    checks++; if (rspId1 !== 2'd0)     begin failures++; $display("[TB] FAIL reset_rspId1 got=%0d want=0", rspId1); end
    checks++; if (busy1 !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy1 got=%b want=0", busy1); end
    checks++; if (sqrtData1 !== 8'h00) begin failures++; $display("[TB] FAIL reset_sqrtData1 got=%h want=00", sqrtData1); end
    checks++; if (rspValid3 !== 4'b0)  begin failures++; $display("[TB] FAIL reset_rspValid3 got=%b want=0000", rspValid3); end
    checks++; if (busy3 !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy3 got=%b want=0", busy3); end
  endtask

  task automatic test_single();
    do_reset();
    nextCycle();
    applyStimulus(4'b0010, 32'h0000_1000, 4'b0, 32'h0);
    #1;
    checks++; if (ready1 !== 4'b0010)  begin failures++; $display("[TB] FAIL single_ready got=%b want=0010", ready1); end
    checks++; if (sqrtData1 !== 8'h10) begin failures++; $display("[TB] FAIL single_sqrtData got=%h want=10", sqrtData1); end
    checks++; if (busy1 !== 1'b0)      begin failures++; $display("[TB] FAIL single_busy_pre got=%b want=0", busy1); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    #1;
    checks++; if (busy1 !== 1'b1)      begin failures++; $display("[TB] FAIL single_busy_mid got=%b want=1", busy1); end
    checks++; if (rspValid1 !== 4'b0)  begin failures++; $display("[TB] FAIL single_rsp_early got=%b want=0000", rspValid1); end
    nextCycle();
    #1;
    checks++; if (rspValid1 !== 4'b0010) begin failures++; $display("[TB] FAIL single_rspValid got=%b want=0010", rspValid1); end
    checks++; if (rspId1 !== 2'd1)       begin failures++; $display("[TB] FAIL single_rspId got=%0d want=1", rspId1); end
    checks++; if (rspData1 !== 8'hEF)    begin failures++; $display("[TB] FAIL single_rspData got=%h want=ef", rspData1); end
    checks++; if (busy1 !== 1'b0)        begin failures++; $display("[TB] FAIL single_busy_post got=%b want=0", busy1); end
    nextCycle();
    #1;
    checks++; if (rspValid1 !== 4'b0)    begin failures++; $display("[TB] FAIL single_strobe_len got=%b want=0000", rspValid1); end
    checks++; if (rspData1 !== 8'hEF)    begin failures++; $display("[TB] FAIL single_data_hold got=%h want=ef", rspData1); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    nextCycle();
    applyStimulus(4'b0101, 32'h0002_0001, 4'b0, 32'h0);
    #1;
    checks++; if (ready1 !== 4'b0001)  begin failures++; $display("[TB] FAIL simul_ready0 got=%b want=0001", ready1); end
    checks++; if (sqrtData1 !== 8'h01) begin failures++; $display("[TB] FAIL simul_data0 got=%h want=01", sqrtData1); end
    nextCycle();
    applyStimulus(4'b0100, 32'h0002_0001, 4'b0, 32'h0);
    #1;
    checks++; if (ready1 !== 4'b0100)  begin failures++; $display("[TB] FAIL simul_ready2 got=%b want=0100", ready1); end
    checks++; if (sqrtData1 !== 8'h02) begin failures++; $display("[TB] FAIL simul_data2 got=%h want=02", sqrtData1); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    #1;
    checks++; if (rspValid1 !== 4'b0001) begin failures++; $display("[TB] FAIL simul_rspValid0 got=%b want=0001", rspValid1); end
    checks++; if (rspId1 !== 2'd0)       begin failures++; $display("[TB] FAIL simul_rspId0 got=%0d want=0", rspId1); end
    checks++; if (rspData1 !== 8'hFE)    begin failures++; $display("[TB] FAIL simul_rspData0 got=%h want=fe", rspData1); end
    nextCycle();
    #1;
    checks++; if (rspValid1 !== 4'b0100) begin failures++; $display("[TB] FAIL simul_rspValid2 got=%b want=0100", rspValid1); end
    checks++; if (rspId1 !== 2'd2)       begin failures++; $display("[TB] FAIL simul_rspId2 got=%0d want=2", rspId1); end
    checks++; if (rspData1 !== 8'hFD)    begin failures++; $display("[TB] FAIL simul_rspData2 got=%h want=fd", rspData1); end
  endtask

  task automatic test_fairness();
    int         grantCnt [4];
    logic [3:0] expGrant;
    logic [3:0] expRsp;
    logic [7:0] expData;
    for (int k = 0; k < 4; k++) grantCnt[k] = 0;
    do_reset();
    nextCycle();
    applyStimulus(4'b1111, 32'h4342_4140, 4'b0, 32'h0);
    for (int n = 0; n < 100; n++) begin
      #1;
      expGrant = 4'(4'b0001 << (n % 4));
      checks++; if (ready1 !== expGrant) begin failures++; $display("[TB] FAIL fair_grant cycle=%0d got=%b want=%b", n, ready1, expGrant); end
      for (int k = 0; k < 4; k++) if (ready1[k]) grantCnt[k]++;
      if (n >= 2) begin
        expRsp  = 4'(4'b0001 << ((n - 2) % 4));
        expData = ~(8'h40 + 8'((n - 2) % 4));
        checks++; if (rspValid1 !== expRsp) begin failures++; $display("[TB] FAIL fair_rsp cycle=%0d got=%b want=%b", n, rspValid1, expRsp); end
        checks++; if (rspData1 !== expData) begin failures++; $display("[TB] FAIL fair_data cycle=%0d got=%h want=%h", n, rspData1, expData); end
      end
      nextCycle();
    end
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (grantCnt[k] != 25) begin failures++; $display("[TB] FAIL fair_count req=%0d got=%0d want=25", k, grantCnt[k]); end
    end
  endtask

  task automatic test_pending_block();
    do_reset();
    nextCycle();
    applyStimulus(4'b1000, 32'h5500_0000, 4'b0, 32'h0);
    #1;
    checks++; if (ready1 !== 4'b1000) begin failures++; $display("[TB] FAIL pend_ready_first got=%b want=1000", ready1); end
    nextCycle();
    #1;
    checks++; if (ready1 !== 4'b0000) begin failures++; $display("[TB] FAIL pend_ready_blocked got=%b want=0000", ready1); end
    checks++; if (busy1 !== 1'b1)     begin failures++; $display("[TB] FAIL pend_busy got=%b want=1", busy1); end
    nextCycle();
    #1;
    checks++; if (rspValid1 !== 4'b1000) begin failures++; $display("[TB] FAIL pend_rspValid got=%b want=1000", rspValid1); end
    checks++; if (rspData1 !== 8'hAA)    begin failures++; $display("[TB] FAIL pend_rspData got=%h want=aa", rspData1); end
    checks++; if (ready1 !== 4'b1000)    begin failures++; $display("[TB] FAIL pend_regrant got=%b want=1000", ready1); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    nextCycle();
    applyStimulus(4'b0010, 32'h0000_2200, 4'b0, 32'h0);
    #1;
    checks++; if (ready1 !== 4'b0010) begin failures++; $display("[TB] FAIL mid_grant got=%b want=0010", ready1); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (rspValid1 !== 4'b0)  begin failures++; $display("[TB] FAIL mid_rspValid got=%b want=0000", rspValid1); end
    checks++; if (busy1 !== 1'b0)      begin failures++; $display("[TB] FAIL mid_busy got=%b want=0", busy1); end
    checks++; if (ready1 !== 4'b0)     begin failures++; $display("[TB] FAIL mid_ready got=%b want=0000", ready1); end
    checks++; if (sqrtData1 !== 8'h00) begin failures++; $display("[TB] FAIL mid_sqrtData got=%h want=00", sqrtData1); end
    checks++; if (rspId1 !== 2'd0)     begin failures++; $display("[TB] FAIL mid_rspId got=%0d want=0", rspId1); end
    nextCycle();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (rspValid1 !== 4'b0) begin failures++; $display("[TB] FAIL mid_stale_rsp cycle=%0d got=%b want=0000", n, rspValid1); end
      nextCycle();
    end
    // From pointer 0 requester 1 wins over 3; a pointer left at 2 would pick 3.
    applyStimulus(4'b1010, 32'h3300_1100, 4'b0, 32'h0);
    #1;
    checks++; if (ready1 !== 4'b0010)  begin failures++; $display("[TB] FAIL mid_ptr_restart got=%b want=0010", ready1); end
    checks++; if (sqrtData1 !== 8'h11) begin failures++; $display("[TB] FAIL mid_ptr_data got=%h want=11", sqrtData1); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
  endtask

  task automatic test_latency3();
    do_reset();
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0001, 32'h0000_0011);
    #1;
    checks++; if (ready3 !== 4'b0001)  begin failures++; $display("[TB] FAIL lat_ready0 got=%b want=0001", ready3); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0010, 32'h0000_2200);
    #1;
    checks++; if (ready3 !== 4'b0010)  begin failures++; $display("[TB] FAIL lat_ready1 got=%b want=0010", ready3); end
    checks++; if (sqrtData3 !== 8'h22) begin failures++; $display("[TB] FAIL lat_data1 got=%h want=22", sqrtData3); end
    checks++; if (rspValid3 !== 4'b0)  begin failures++; $display("[TB] FAIL lat_early1 got=%b want=0000", rspValid3); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0100, 32'h0033_0000);
    #1;
    checks++; if (ready3 !== 4'b0100)  begin failures++; $display("[TB] FAIL lat_ready2 got=%b want=0100", ready3); end
    checks++; if (rspValid3 !== 4'b0)  begin failures++; $display("[TB] FAIL lat_early2 got=%b want=0000", rspValid3); end
    nextCycle();
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    #1;
    checks++; if (rspValid3 !== 4'b0)  begin failures++; $display("[TB] FAIL lat_early3 got=%b want=0000", rspValid3); end
    checks++; if (busy3 !== 1'b1)      begin failures++; $display("[TB] FAIL lat_busy got=%b want=1", busy3); end
    nextCycle();
    #1;
    checks++; if (rspValid3 !== 4'b0001) begin failures++; $display("[TB] FAIL lat_rspValid0 got=%b want=0001", rspValid3); end
    checks++; if (rspId3 !== 2'd0)       begin failures++; $display("[TB] FAIL lat_rspId0 got=%0d want=0", rspId3); end
    checks++; if (rspData3 !== 8'hEE)    begin failures++; $display("[TB] FAIL lat_rspData0 got=%h want=ee", rspData3); end
    nextCycle();
    #1;
    checks++; if (rspValid3 !== 4'b0010) begin failures++; $display("[TB] FAIL lat_rspValid1 got=%b want=0010", rspValid3); end
    checks++; if (rspId3 !== 2'd1)       begin failures++; $display("[TB] FAIL lat_rspId1 got=%0d want=1", rspId3); end
    checks++; if (rspData3 !== 8'hDD)    begin failures++; $display("[TB] FAIL lat_rspData1 got=%h want=dd", rspData3); end
    nextCycle();
    #1;
    checks++; if (rspValid3 !== 4'b0100) begin failures++; $display("[TB] FAIL lat_rspValid2 got=%b want=0100", rspValid3); end
    checks++; if (rspId3 !== 2'd2)       begin failures++; $display("[TB] FAIL lat_rspId2 got=%0d want=2", rspId3); end
    checks++; if (rspData3 !== 8'hCC)    begin failures++; $display("[TB] FAIL lat_rspData2 got=%h want=cc", rspData3); end
    nextCycle();
    #1;
    checks++; if (rspValid3 !== 4'b0)    begin failures++; $display("[TB] FAIL lat_rsp_end got=%b want=0000", rspValid3); end
    checks++; if (busy3 !== 1'b0)        begin failures++; $display("[TB] FAIL lat_busy_end got=%b want=0", busy3); end
  endtask

  // Scenarios run in sequence; each one starts from its own reset.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(4'b0, 32'h0, 4'b0, 32'h0);
    $display("[TB] starting sqrt_req_arbiter bench");
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_pending_block();
    test_reset_midflight();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
